axis_packet_scheduler: RTL

Sequencer for the dual-input AXI4-Stream packet mux: it drives the mux's select, length and one-shot enable controls directly, runs a programmed sequence of N packets (single-source or alternating ch0/ch1), inserts a programmable idle gap between packets, and watches the mux output for TLAST to advance. It sits between the software-facing CSR bank and the mux, so a multi-packet DMA capture needs one `start` instead of N CSR writes.

---
 rtl/axis_packet_scheduler.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/axis_packet_scheduler.sv
// axis_packet_scheduler
//   Sequences the dual-input AXI4-Stream packet mux. One start pulse runs a
//   programmed sequence of packets (single channel or alternating ch0/ch1).
//   For each packet it loads the mux select and length, fires a one-shot arm
//   pulse and waits for TLAST on the mux output. A programmable idle gap is
//   inserted between packets.
//
//   Optional feature macro: SCHED_TIMEOUT_EN adds a RUN-state watchdog that
//   aborts the sequence and sets timeout_err after TIMEOUT_CYCLES cycles
//   without an end beat. Without the macro, RUN waits indefinitely and
//   timeout_err is tied low.
//
//   Ports
//     aclk, areset        clock, asynchronous active-high reset
//     start, stop         one-cycle control pulses
//     cfg_mode            0 ch0, 1 ch1, 2 alternate from ch0, 3 alternate from ch1
//     cfg_len0/len1       per-channel packet length (beats)
//     cfg_count           packets per sequence (0 runs one packet)
//     cfg_gap             idle cycles between packets
//     mon_tvalid/tready/tlast  taps of the mux master output
//     mux_sel, mux_length, mux_arm, mux_abort  mux controls
//     busy, done, pkt_index, timeout_err       status
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no sequence; waits for start
//   SETUP | loads mux_sel / mux_length for packet pkt_index
//   ARM   | mux_arm is high for this single cycle
//   RUN   | waits for the end beat (valid & ready & last)
//   GAP   | counts cfg_gap idle cycles before the next SETUP
module axis_packet_scheduler #(
  parameter int LENGTH_WIDTH   = 14,
  parameter int COUNT_WIDTH    = 16,
  parameter int GAP_WIDTH      = 16,
  parameter int TIMEOUT_WIDTH  = 24,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    start,
  input  logic                    stop,
  input  logic [1:0]              cfg_mode,
  input  logic [LENGTH_WIDTH-1:0] cfg_len0,
  input  logic [LENGTH_WIDTH-1:0] cfg_len1,
  input  logic [COUNT_WIDTH-1:0]  cfg_count,
  input  logic [GAP_WIDTH-1:0]    cfg_gap,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic                    mux_sel,
  output logic [LENGTH_WIDTH-1:0] mux_length,
  output logic                    mux_arm,
  output logic                    mux_abort,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  pkt_index,
  output logic                    timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_ARM   = 3'd2,
    S_RUN   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [1:0]              mode_q;
  logic [LENGTH_WIDTH-1:0] len0_q;
  logic [LENGTH_WIDTH-1:0] len1_q;
  logic [COUNT_WIDTH-1:0]  last_idx_q;
  logic [GAP_WIDTH-1:0]    gap_q;
  logic [GAP_WIDTH-1:0]    gap_cnt;

  logic end_beat;
  logic tmo_hit;
  logic start_acc;
  logic abort_nxt;
  logic done_nxt;
  logic advance;
  logic tmo_fire;
  logic ch_sel;

  assign end_beat = mon_tvalid & mon_tready & mon_tlast;

  always_comb begin
    ch_sel = 1'b0;
    case (mode_q)
      2'd0:    ch_sel = 1'b0;
      2'd1:    ch_sel = 1'b1;
      2'd2:    ch_sel = pkt_index[0];
      default: ch_sel = ~pkt_index[0];
    endcase
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    abort_nxt = 1'b0;
    done_nxt  = 1'b0;
    advance   = 1'b0;
    tmo_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        // start and stop together in IDLE is a no-op
        if (start && !stop) begin
          state_nxt = S_SETUP;
          start_acc = 1'b1;
        end
      end
      S_SETUP: state_nxt = S_ARM;
      S_ARM:   state_nxt = S_RUN;
      S_RUN: begin
        // end beat has priority over a watchdog expiry in the same cycle
        if (end_beat) begin
          if (pkt_index != last_idx_q) begin
            advance   = 1'b1;
            state_nxt = (gap_q == '0) ? S_SETUP : S_GAP;
          end else begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          abort_nxt = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_WIDTH'(1)) state_nxt = S_SETUP;
      end
      default: state_nxt = S_IDLE;
    endcase
    // stop overrides everything, including a coincident end beat
    if (state != S_IDLE && stop) begin
      state_nxt = S_IDLE;
      abort_nxt = 1'b1;
      done_nxt  = 1'b0;
      advance   = 1'b0;
      tmo_fire  = 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      mux_arm    <= 1'b0;
      mux_abort  <= 1'b0;
      done       <= 1'b0;
      mux_sel    <= 1'b0;
      mux_length <= '0;
      pkt_index  <= '0;
      mode_q     <= 2'd0;
      len0_q     <= '0;
      len1_q     <= '0;
      last_idx_q <= '0;
      gap_q      <= '0;
      gap_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      busy      <= (state_nxt != S_IDLE);
      mux_arm   <= (state_nxt == S_ARM);
      mux_abort <= abort_nxt;
      done      <= done_nxt;

      if (start_acc) begin
        mode_q     <= cfg_mode;
        len0_q     <= cfg_len0;
        len1_q     <= cfg_len1;
        gap_q      <= cfg_gap;
        last_idx_q <= (cfg_count == '0) ? '0 : cfg_count - COUNT_WIDTH'(1);
        pkt_index  <= '0;
      end

      if (advance) begin
        pkt_index <= pkt_index + COUNT_WIDTH'(1);
        gap_cnt   <= gap_q;
      end else if (state == S_GAP) begin
        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
      end

      if (state == S_SETUP) begin
        mux_sel    <= ch_sel;
        mux_length <= ch_sel ? len1_q : len0_q;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  // Down-counter loaded on RUN entry; terminal count 1 marks the last
  // allowed RUN cycle.
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;

  assign tmo_hit = (state == S_RUN) && (tmo_cnt == TIMEOUT_WIDTH'(1));

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == S_ARM) begin
        tmo_cnt <= TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
      end else if (state == S_RUN) begin
        tmo_cnt <= tmo_cnt - TIMEOUT_WIDTH'(1);
      end
      if (start_acc) begin
        timeout_err <= 1'b0;
      end else if (tmo_fire) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
